// File: rtl/misr_pkg.sv
// Shared types, defaults and the MISR next-state function for the response compactor.
package misr_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } misr_state_e;

  localparam logic [7:0] MISR_POLY_DEF = 8'h1D;
  localparam logic [7:0] MISR_SEED_DEF = 8'h00;
  localparam int unsigned MISR_MAX_W   = 64;

  // Width-generic MISR step: callers widen to MISR_MAX_W and cast the result back.
  function automatic logic [MISR_MAX_W-1:0] misr_next(
    input logic [MISR_MAX_W-1:0] sig,
    input logic [MISR_MAX_W-1:0] poly,
    input logic [MISR_MAX_W-1:0] din,
    input int unsigned           sig_w
  );
    logic [MISR_MAX_W-1:0] mask;
    logic [MISR_MAX_W-1:0] shifted;
    mask    = (MISR_MAX_W'(1) << sig_w) - MISR_MAX_W'(1);
    shifted = (sig << 1) & mask;
    if (((sig >> (sig_w - 1)) & MISR_MAX_W'(1)) != '0) begin
      shifted = shifted ^ poly;
    end
    return (shifted ^ din) & mask;
  endfunction

endpackage

// File: rtl/misr_core.sv
// Multiple-input signature register: synchronous seed load, enable-gated fold of one response.
module misr_core
  import misr_pkg::*;
#(
  parameter int unsigned           RESP_W = 3,
  parameter int unsigned           SIG_W  = 8,
  parameter logic [SIG_W-1:0]      POLY   = SIG_W'(MISR_POLY_DEF),
  parameter logic [SIG_W-1:0]      SEED   = SIG_W'(MISR_SEED_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_en,
  input  logic [RESP_W-1:0] i_din,
  output logic [SIG_W-1:0]  o_sig
);

  logic [SIG_W-1:0] r_sig;
  logic [SIG_W-1:0] w_sig_nxt;

  assign w_sig_nxt = SIG_W'(misr_next(MISR_MAX_W'(r_sig), MISR_MAX_W'(POLY),
                                      MISR_MAX_W'(i_din), SIG_W));

  // Seed load wins over an update so a new session always starts clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sig <= SEED;
    end else if (i_load) begin
      r_sig <= SEED;
    end else if (i_en) begin
      r_sig <= w_sig_nxt;
    end
  end

  assign o_sig = r_sig;

endmodule

// File: rtl/misr_resp_compactor.sv
// BIST response compactor: FSM, pattern counter, golden latch and final compare around misr_core.
// Define MISR_XMASK_EN to add the resp_mask X-masking input.
module misr_resp_compactor
  import misr_pkg::*;
#(
  parameter int unsigned      RESP_W = 3,
  parameter int unsigned      SIG_W  = 8,
  parameter logic [SIG_W-1:0] POLY   = SIG_W'(MISR_POLY_DEF),
  parameter logic [SIG_W-1:0] SEED   = SIG_W'(MISR_SEED_DEF),
  parameter int unsigned      CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_patterns,
  input  logic [SIG_W-1:0]  golden,
  input  logic              resp_valid,
  input  logic [RESP_W-1:0] resp,
`ifdef MISR_XMASK_EN
  input  logic [RESP_W-1:0] resp_mask,
`endif
  output logic              resp_ready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature
);

  misr_state_e       r_state;
  misr_state_e       w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_num;
  logic [SIG_W-1:0]  r_golden;
  logic              r_pass;
  logic              w_load;
  logic              w_accept;
  logic [RESP_W-1:0] w_resp;

`ifdef MISR_XMASK_EN
  assign w_resp = resp & ~resp_mask;
`else
  assign w_resp = resp;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = (num_patterns == '0) ? S_CHECK : S_RUN;
        end
      end
      S_RUN: begin
        w_accept = resp_valid;
        if (resp_valid && (r_cnt == r_num - CNT_W'(1))) begin
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_num    <= '0;
      r_golden <= '0;
      r_pass   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_cnt    <= '0;
        r_num    <= num_patterns;
        r_golden <= golden;
        r_pass   <= 1'b0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (r_state == S_CHECK) begin
        r_pass <= (signature == r_golden);
      end
    end
  end

  misr_core #(
    .RESP_W (RESP_W),
    .SIG_W  (SIG_W),
    .POLY   (POLY),
    .SEED   (SEED)
  ) u_misr_core (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_en   (w_accept),
    .i_din  (w_resp),
    .o_sig  (signature)
  );

  assign resp_ready = (r_state == S_RUN);
  assign busy       = (r_state == S_RUN) || (r_state == S_CHECK);
  assign done       = (r_state == S_DONE);
  assign pass       = r_pass;

endmodule

// File: doc/misr_resp_compactor.md
# misr_resp_compactor

Built-in self-test response compactor placed directly downstream of a combinational circuit under test (e.g. the 3-input/3-output x3mult benchmark). Each accepted response vector from the CUT outputs is folded into a multiple-input signature register (MISR). A control FSM counts a programmed number of patterns, compares the final signature against a golden value, and reports pass/fail.

## Interface
- `RESP_W`, 3: width of the CUT response vector.
- `SIG_W`, 8: MISR width; must be ≥ `RESP_W`.
- `POLY`, 8'h1D: feedback polynomial taps (x^8+x^4+x^3+x^2+1), bit i = tap i.
- `SEED`, 8'h00: MISR value loaded on start.
- `CNT_W`, 16: pattern counter width.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a session; sampled in IDLE or DONE only.
- `num_patterns` in CNT_W: response count for the session; sampled with `start`.
- `golden` in SIG_W: expected signature; sampled with `start`.
- `resp_valid` in 1: `resp` carries a valid CUT response.
- `resp` in RESP_W: CUT output vector, e.g. {N38,N39,N40}.
- `resp_mask` in RESP_W: X-mask, present only with `MISR_XMASK_EN`.
- `resp_ready` out 1: compactor accepts a response this cycle.
- `busy` out 1: session in progress (RUN or CHECK).
- `done` out 1: session complete; `pass` valid.
- `pass` out 1: final signature equals golden.
- `signature` out SIG_W: current MISR contents.

## Operation
- FSM states: IDLE, RUN, CHECK, DONE.
- IDLE/DONE + `start`: load MISR←`SEED`, counter←0, latch `num_patterns` and `golden`; go to RUN, or to CHECK if `num_patterns`==0.
- RUN: `resp_ready`=1. A response is accepted when `resp_valid && resp_ready`. When the counter reaches `num_patterns`-1 on an accepted response, go to CHECK.
- MISR update on accept: `sig_next = (sig << 1) ^ (sig[SIG_W-1] ? POLY : 0) ^ zero_ext(resp)`. The shift drops the MSB. Feedback uses the pre-shift MSB.
- CHECK (one cycle): register `pass = (signature == golden_latched)`; go to DONE.
- DONE: `done`=1. `pass` and `signature` hold until the next `start`.
- `start` in RUN/CHECK: ignored; the latched parameters do not change.
- `resp_valid` outside RUN: ignored; MISR unchanged.
- Counter uses `CNT_W` unsigned arithmetic; `num_patterns`=2^CNT_W-1 is the maximum session length; no wrap within a session.

## Timing
- Reset values: state IDLE, `signature`=`SEED`, counter 0, `resp_ready`=0, `busy`=0, `done`=0, `pass`=0.
- `start` at edge t: `busy`=1 and `resp_ready`=1 from cycle t+1.
- Final accept at edge k: CHECK during cycle k+1; `done`=1 and `pass` valid from edge k+2.
- `num_patterns`=0 with `start` at edge t: CHECK in cycle t+1; `done` from edge t+2; `signature`=`SEED`.
- `signature` updates one edge after each accept; no combinational path from `resp` to any output.
- `rst` mid-session: returns to reset values at that edge; the partial signature is lost.
- `rst` and `start` in the same cycle: `rst` wins.

## Configuration
- `MISR_XMASK_EN` defined: `resp_mask` port exists. The compacted vector is `resp & ~resp_mask`, so unknown CUT outputs cannot corrupt the signature.
- Not defined: no `resp_mask` port; `resp` is compacted unmasked.

## Structure
- `misr_pkg`: FSM state enum (IDLE, RUN, CHECK, DONE), default `POLY`/`SEED` localparams, MISR next-state function.
- Sub-module `misr_core`: the SIG_W register with synchronous load-seed and enable-update inputs.
- Top level holds the FSM, counter, golden latch and compare.

## Test plan
- Reset, then idle 5 cycles -> `signature`=8'h00; `busy`, `done`, `pass`, `resp_ready` all 0.
- `num_patterns`=1, `resp`=3'b101, `golden`=8'h05 -> `signature`=8'h05; `done`=1 two edges after accept; `pass`=1.
- `num_patterns`=2, responses 3'b111 then 3'b001, `golden`=8'h0F -> `pass`=1. Same session with `golden`=8'h0E -> `pass`=0.
- `num_patterns`=9, all `resp`=3'b001, `resp_valid` toggled every other cycle -> `signature` after 8 accepts is 8'hFF, final is 8'hE2 (feedback exercised); only valid cycles counted.
- `num_patterns`=0 -> `done` two edges after `start`; `signature`=`SEED`; `pass`=(`golden`==`SEED`). `start` pulsed during a RUN session -> ignored.
- `rst` asserted after 3 of 9 accepts -> all outputs return to reset values next edge. A fresh session then reproduces 8'hE2. With `MISR_XMASK_EN`, `resp`=3'b111 and `resp_mask`=3'b110 -> compacts as 3'b001.
